// File: rtl/param_sync_fifo_if.sv
// Handshake bundle for param_sync_fifo.
// master = producer/consumer side, slave = FIFO side.
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  over_flow;
  logic                  under_flow;

  modport master (
    output flush, write_en, data_in, read_en,
    input  data_out, valid, full, empty,
    input  almost_full, almost_empty, count,
    input  over_flow, under_flow
  );

  modport slave (
    input  flush, write_en, data_in, read_en,
    output data_out, valid, full, empty,
    output almost_full, almost_empty, count,
    output over_flow, under_flow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with fill count, flush, error pulses
// and selectable registered / fall-through read port.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input logic              clk,
  input logic              reset,
  param_sync_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full, empty;
  logic                  rd_acc, wr_acc;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Accept/reject decisions and next-state; flush overrides all.
  always_comb begin
    rd_acc   = !bus.flush && bus.read_en && !empty;
    wr_acc   = !bus.flush && bus.write_en
             && (!full || rd_acc);
    ovf_d    = !bus.flush && bus.write_en
             && full && !rd_acc;
    udf_d    = !bus.flush && bus.read_en && empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // FWFT remembers the presented word so it can hold once drained.
    if (FWFT != 0) begin
      if (!empty) dout_d = mem[rd_ptr_q];
    end else if (rd_acc) begin
      dout_d  = mem[rd_ptr_q];
      valid_d = 1'b1;
    end
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.data_in;
  end

  assign bus.data_out     = (FWFT != 0 && !empty)
                          ? mem[rd_ptr_q] : dout_q;
  assign bus.valid        = (FWFT != 0) ? !empty : valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.count        = count_q;
  assign bus.over_flow    = ovf_q;
  assign bus.under_flow   = udf_q;
endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Single-clock FIFO with parametrised data width, depth and almost-full/almost-empty thresholds. It has a selectable read mode: registered read (1-cycle latency) or first-word-fall-through (FWFT). It adds a fill count, a synchronous flush and one-cycle overflow/underflow error pulses. It is the single-clock successor to async_fifo, for buffering between same-clock producer and consumer stages.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out in bits
DEPTH, 16, number of entries; power of two, >= 2
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL; range 1..DEPTH
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL; range 0..DEPTH-1
FWFT, 0, 0 = registered read mode, 1 = first-word-fall-through mode

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of FIFO contents and status
write_en  input  1  write request
data_in  input  DATA_WIDTH  write data
read_en  input  1  read request (FWFT: pop acknowledge)
data_out  output  DATA_WIDTH  read data
valid  output  1  data_out holds a valid word (see Behaviour)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
over_flow  output  1  one-cycle pulse: write rejected
under_flow  output  1  one-cycle pulse: read rejected

Behaviour:
- Storage: DEPTH x DATA_WIDTH array. Pointers wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is a registered counter.
- Status flags: full, empty, almost_full and almost_empty are derived from registered count only. They update in the cycle after the operation that changes count.
- Reset (reset=0, asynchronous assert): pointers=0, count=0, data_out=0, valid=0, full=0, empty=1, almost_full=0, almost_empty=1, over_flow=0, under_flow=0. Memory contents are not reset.
- Deassertion of reset is taken synchronously at the next clk edge. Reset mid-operation discards all stored data.
- Write accepted: write_en && (!full || read accepted in same cycle). Stores data_in at wr_ptr, then wr_ptr+1.
- Write rejected: write_en && full && no accepted read. over_flow=1 for one cycle, contents unchanged.
- Read accepted: read_en && !empty. rd_ptr+1.
- Read rejected: read_en && empty. under_flow=1 for one cycle. A same-cycle write on empty is still accepted.
- Simultaneous accepted read+write: count unchanged. When full, both succeed and full stays 1.
- count: +1 on write only, -1 on read only, unchanged otherwise. Never exceeds DEPTH or goes below 0.
- FWFT=0 (registered read):
  - On an accepted read, data_out <= mem[rd_ptr] and valid=1 for exactly the next cycle. Latency is 1 clk from read_en.
  - When no read is accepted, valid=0 and data_out holds its last value.
- FWFT=1 (fall-through):
  - data_out = mem[rd_ptr] whenever !empty; valid = !empty.
  - A word written to an empty FIFO appears on data_out with valid=1 in the cycle after the write.
  - read_en with valid pops the word; the next word is presented in the following cycle. When empty, data_out holds its last value.
- flush=1 at clk edge:
  - pointers=0, count=0, valid=0, over_flow=0, under_flow=0; flags return to reset values next cycle; data_out holds.
  - flush has priority: write_en/read_en in the same cycle are ignored and raise no error pulses.
- Error pulses are registered and asserted in the cycle after the offending request. Back-to-back rejected requests give continuous assertion.

Test Plan:
(DATA_WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1)
1. Reset values: hold reset=0, then release. Required: empty=1, almost_empty=1, count=0, full=0, valid=0, data_out=0x00. Then write 0x11, 0x22, 0x33. Required: count=3, almost_empty=0 after the 2nd write.
2. Fill to full, FWFT=0: write 0x01..0x08. Required: almost_full=1 at count=6, full=1 at count=8. A 9th write (0x09) gives over_flow=1 for one cycle and count stays 8. Read 8 times. Required: data_out 0x01..0x08 in order, each with valid=1 one cycle after read_en, and empty=1 at the end.
3. Underflow: read_en=1 on empty for 2 cycles. Required: under_flow=1 for 2 cycles, count=0, valid=0.
4. Simultaneous read and write: at count=8, read+write 0xAA in the same cycle. Required: no over_flow, count=8, full=1, 0xAA read last. At count=0, read+write 0x55 together. Required: under_flow=1, count=1.
5. FWFT=1: write 0xC3 to empty. Required: next cycle valid=1 and data_out=0xC3 without read_en. Write 0xD4, then pulse read_en. Required: next cycle data_out=0xD4, count=1.
6. Flush and reset mid-operation: at count=5, assert flush together with write_en. Required: next cycle count=0, empty=1, no over_flow. Refill 3 words, then assert reset asynchronously between edges. Required: count=0 and empty=1 immediately.
